// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared types and helpers for the BRAM stream reader
package bram_stream_pkg;

    // Number of bits needed to hold value (never less than 1).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Travels alongside each RAM read so returning data knows it is real and whether it ends the command.
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/bram_stream_fifo.sv
// rtl/bram_stream_fifo.sv - synchronous FIFO with fall-through when empty
module bram_stream_fifo
    import bram_stream_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // An empty FIFO presents the incoming word directly so a same-cycle write+read passes straight through.
    assign rd_data_o = empty_o ? wr_data_i : mem_q[rd_ptr_q];

    // Decide what actually moves: pass-through, store, and/or retire the head.
    always_comb begin
        bypass   = empty_o & wr_en_i & rd_en_i;
        push     = wr_en_i & (~full_o | rd_en_i) & ~bypass;
        pop      = rd_en_i & ~empty_o;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - BRAM read initiator to valid/ready stream; BRAM_STREAM_READER_WRAP_EN enables address wrap
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    localparam int AW = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [AW-1:0]        cmd_base,
    input  logic [AW:0]          cmd_len,
    output logic                 cmd_err,
    output logic                 busy,
    output logic                 done,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic [AW-1:0]        ram_addra,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic                 ram_rsta,
    output logic                 ram_regcea,
    input  logic [RAM_WIDTH-1:0] ram_douta
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW  = clogb2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d, addr_next;
    logic [AW:0]          remain_q, remain_d;
    logic                 cmd_err_q, cmd_err_d;
    tag_t                 pipe_q [READ_LATENCY];
    tag_t                 new_tag;
    tag_t                 exit_tag;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic [RAM_WIDTH-1:0] m_data_q, m_data_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FCW-1:0]       fifo_count;
    logic [RAM_WIDTH:0]   fifo_head;
    logic                 head_valid;
    logic                 load_out;
    logic                 pop_out;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        used;
    logic                 credit_ok;
    logic                 issue;
    logic                 range_bad;

`ifdef BRAM_STREAM_READER_WRAP_EN
    // Addresses roll over at the end of the RAM, so every base is usable.
    assign addr_next = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
    assign range_bad = 1'b0;
`else
    logic [AW+1:0] cmd_end;
    assign addr_next = addr_q + AW'(1);
    assign cmd_end   = (AW+2)'(cmd_base) + (AW+2)'(cmd_len);
    assign range_bad = (cmd_end > (AW+2)'(RAM_DEPTH));
`endif

    // Count reads still travelling through the RAM latency.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding = outstanding + CW'(pipe_q[i].valid);
        end
    end

    // Every read reserves a buffer slot up front; the output register counts as a slot,
    // and a beat leaving this cycle frees its slot before any new read can land.
    assign used      = outstanding + CW'(fifo_count) + CW'(m_valid_q);
    assign credit_ok = ~fifo_full & (used < (CW'(FIFO_DEPTH) + CW'(pop_out)));
    assign issue     = (state_q == ST_ISSUE) & (remain_q != '0) & credit_ok;
    assign new_tag   = '{valid: issue, last: issue & (remain_q == (AW+1)'(1))};
    assign exit_tag  = pipe_q[READ_LATENCY-1];

    bram_stream_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clka),
        .rst_i     (rsta),
        .wr_en_i   (exit_tag.valid),
        .wr_data_i ({exit_tag.last, ram_douta}),
        .rd_en_i   (load_out),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign head_valid = ~fifo_empty | exit_tag.valid;
    assign pop_out    = m_valid_q & m_ready;
    assign load_out   = head_valid & (~m_valid_q | m_ready);

    // Output register: refill from the FIFO head whenever it is empty or being consumed, otherwise hold.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (load_out) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_head[RAM_WIDTH-1:0];
            m_last_d  = fifo_head[RAM_WIDTH];
        end else if (pop_out) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    // Command FSM next state: accept/reject, issue reads under credit, wait for the final beat.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        cmd_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else if (range_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d  = ST_ISSUE;
                        addr_d   = cmd_base;
                        remain_d = cmd_len;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d   = addr_next;
                    remain_d = remain_q - (AW+1)'(1);
                    if (remain_q == (AW+1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop_out & m_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            cmd_err_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            cmd_err_q <= cmd_err_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    // Tag shift register mirroring the RAM read latency; clearing it drops any data still in flight.
    always_ff @(posedge clka) begin
        if (rsta) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign cmd_err    = cmd_err_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign ram_addra  = addr_q;
    assign ram_ena    = issue;
    assign ram_wea    = 1'b0;
    assign ram_rsta   = rsta;
    assign ram_regcea = 1'b1;

endmodule
